lsu_mem_master: RTL and testbench

//  Load/store unit driving the word-wide Data_Memory port (addr, wdata, rdata, we) from the core side.

---
 rtl/lsu_mem_master.sv | 138 +++++++++++++
 tb/tb_lsu_mem_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit in front of a word-wide Data_Memory port.
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_mem_master #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS * 4);

    state_t      state, state_nx;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_err;
    logic [4:0]  sh;
    logic [15:0] rd_lane;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_addr >= LIMIT);

    // Half accesses are aligned, so one byte-granular shift serves both sizes.
    assign sh        = {lane_q, 3'b000};
    assign rd_lane   = 16'(mem_rdata >> sh);
    assign lane_mask = (size_q == 2'b00) ? (32'h0000_00ff << sh)
                                         : (32'h0000_ffff << sh);
    assign merged    = (mem_rdata & ~lane_mask)
                     | (({16'h0000, wdata_q} << sh) & lane_mask);

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & rd_lane[7]}}, rd_lane[7:0]};
            2'b01:   load_ext = {{16{~uns_q & rd_lane[15]}}, rd_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_we && req_size == 2'b10)
                        state_nx = WRITE;
                    else
                        state_nx = READ;
                end
            end
            READ:  state_nx = we_q ? WRITE : RESP;
            WRITE: begin
                mem_we   = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            wdata_q   <= 16'h0000;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    uns_q     <= req_unsigned;
                    size_q    <= req_size;
                    lane_q    <= req_addr[1:0];
                    wdata_q   <= req_wdata[15:0];
                    mem_wdata <= req_wdata;
                    rsp_err   <= req_err;
                    rsp_rdata <= 32'h0;
                    if (!req_err)
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                end
                READ: begin
                    if (we_q) mem_wdata <= merged;
                    else      rsp_rdata <= load_ext;
                end
                RESP: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural Data_Memory.
// Directed loads/stores, error cases, back-to-back traffic and mid-op reset.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;

    lsu_mem_master #(.ADDR_W(32), .MEM_WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk) begin
        #1;
        if (rsp_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%0b data=%h, required none",
                         rsp_err, rsp_rdata);
            end else begin
                e = q.pop_front();
                if (rsp_err !== e.err || rsp_rdata !== e.data
                    || (cyc - e.acc) != e.lat) begin
                    n_fail++;
                    $display("FAIL %s: got err=%0b data=%h lat=%0d, required err=%0b data=%h lat=%0d",
                             e.name, rsp_err, rsp_rdata, cyc - e.acc,
                             e.err, e.data, e.lat);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, want);
        end
    endtask

    // lat counts edges after the accept edge until the response cycle.
    task automatic issue(input string nm, input logic we,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic xerr, input logic [31:0] xdata,
                         input int lat, input bit hold);
        exp_t x;
        int   k;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk({nm, "_accept_timeout"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        x.name = nm;
        x.err  = xerr;
        x.data = xdata;
        x.lat  = lat;
        x.acc  = cyc;
        q.push_back(x);
        chk({nm, "_ready_low"}, 32'(req_ready), 32'h0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 32'(q.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    int w0;

    initial begin
        #2;
        chk("rst_ready",     32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_mem_addr",  mem_addr,       32'h0);
        chk("rst_mem_wdata", mem_wdata,      32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        w0 = wr_cnt;
        issue("sw_04", 1, 2'b10, 0, 32'h04, 32'hDEADBEEF, 0, 32'h0, 1, 0);
        drain();
        chk("sw_04_writes", 32'(wr_cnt - w0), 32'h1);
        chk("sw_04_waddr",  last_wr_addr,     32'h04);
        chk("sw_04_mem",    mem[1],           32'hDEADBEEF);

        w0 = wr_cnt;
        issue("sb_05", 1, 2'b00, 0, 32'h05, 32'h00000012, 0, 32'h0, 2, 0);
        drain();
        chk("sb_05_writes", 32'(wr_cnt - w0), 32'h1);
        chk("sb_05_mem",    mem[1],           32'hDEAD12EF);

        issue("lw_04",  0, 2'b10, 0, 32'h04, 32'h0, 0, 32'hDEAD12EF, 1, 1);
        issue("lb_07",  0, 2'b00, 0, 32'h07, 32'h0, 0, 32'hFFFFFFDE, 1, 1);
        issue("lbu_07", 0, 2'b00, 1, 32'h07, 32'h0, 0, 32'h000000DE, 1, 1);
        issue("lh_06",  0, 2'b01, 0, 32'h06, 32'h0, 0, 32'hFFFFDEAD, 1, 1);
        issue("lhu_04", 0, 2'b01, 1, 32'h04, 32'h0, 0, 32'h000012EF, 1, 1);
        drain();

        issue("sw_08", 1, 2'b10, 0, 32'h08, 32'h11223344, 0, 32'h0, 1, 1);
        issue("sw_fc", 1, 2'b10, 0, 32'hFC, 32'hCAFEF00D, 0, 32'h0, 1, 1);
        issue("lw_fc", 0, 2'b10, 0, 32'hFC, 32'h0, 0, 32'hCAFEF00D, 1, 1);
        drain();

        w0 = wr_cnt;
        issue("lw_02_err",  0, 2'b10, 0, 32'h02,  32'h0, 1, 32'h0, 0, 1);
        issue("lh_03_err",  0, 2'b01, 0, 32'h03,  32'h0, 1, 32'h0, 0, 1);
        issue("sz11_err",   0, 2'b11, 0, 32'h00,  32'h0, 1, 32'h0, 0, 1);
        issue("lw_100_err", 0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0, 0, 1);
        issue("sw_100_err", 1, 2'b10, 0, 32'h100, 32'h5, 1, 32'h0, 0, 1);
        issue("sb_big_err", 1, 2'b00, 0, 32'h80000001, 32'h5, 1, 32'h0, 0, 1);
        drain();
        chk("err_no_writes", 32'(wr_cnt - w0), 32'h0);

        // Abort an SH to word 2 while it sits in READ.
        w0 = wr_cnt;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we),    32'h0);
        chk("abort_ready",  32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_writes", 32'(wr_cnt - w0), 32'h0);
        chk("abort_mem2",   mem[2],           32'h11223344);
        issue("lw_08_after_abort", 0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h11223344, 1, 0);
        drain();

        issue("sh_0a",  1, 2'b01, 0, 32'h0A, 32'hFFFF8001, 0, 32'h0, 2, 1);
        issue("lw_08",  0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h80013344, 1, 1);
        issue("lh_0a",  0, 2'b01, 0, 32'h0A, 32'h0, 0, 32'hFFFF8001, 1, 1);
        issue("lhu_0a", 0, 2'b01, 1, 32'h0A, 32'h0, 0, 32'h00008001, 1, 1);
        issue("lbu_0a", 0, 2'b00, 1, 32'h0A, 32'h0, 0, 32'h00000001, 1, 1);
        issue("lb_0b",  0, 2'b00, 0, 32'h0B, 32'h0, 0, 32'hFFFFFF80, 1, 1);
        issue("lb_08",  0, 2'b00, 0, 32'h08, 32'h0, 0, 32'h00000044, 1, 1);
        drain();
        chk("sh_0a_mem", mem[2], 32'h80013344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
